// File: rtl/viterbi_traceback_if.sv
// Handshake bundle between the ACS/selector stage, the traceback block and the bit sink.
// master = surrounding datapath, slave = traceback block.
interface viterbi_traceback_if;
   logic       surv_valid;
   logic [3:0] surv;
   logic       blk_last;
   logic [1:0] best_state;
   logic       in_ready;
   logic       bit_out;
   logic       bit_valid;
   logic       bit_last;
   logic       out_ready;
   logic       busy;

   modport master (
      output surv_valid, surv, blk_last, best_state, out_ready,
      input  in_ready, bit_out, bit_valid, bit_last, busy
   );

   modport slave (
      input  surv_valid, surv, blk_last, best_state, out_ready,
      output in_ready, bit_out, bit_valid, bit_last, busy
   );
endinterface

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the 4-state K=3 Viterbi decoder.
// Collects a block of decision vectors, traces back from the best state, then streams bits in time order.
module viterbi_traceback #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input logic               clk,
   input logic               rst,
   viterbi_traceback_if.slave vif
);

   typedef enum logic [1:0] {
      S_WRITE  = 2'd0,
      S_TRACE  = 2'd1,
      S_OUTPUT = 2'd2
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   idx_inc;
   logic [1:0]          trace_q, trace_d;
   logic [3:0]          mem_q [DEPTH];
   logic [3:0]          mem_d [DEPTH];
   logic [DEPTH-1:0]    dbuf_q, dbuf_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                bit_out_q, bit_out_d;
   logic                bit_valid_q, bit_valid_d;
   logic                bit_last_q, bit_last_d;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      last_d      = last_q;
      idx_d       = idx_q;
      idx_inc     = idx_q + 1'b1;
      trace_d     = trace_q;
      mem_d       = mem_q;
      dbuf_d      = dbuf_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = bit_valid_q;
      bit_last_d  = bit_last_q;

      case (state_q)
         S_WRITE: begin
            if (vif.surv_valid) begin
               mem_d[wcnt_q] = vif.surv;
               // Block end: last_q holds N-1, which is also the first traceback index.
               if (vif.blk_last || (wcnt_q == LAST_STEP)) begin
                  last_d     = wcnt_q;
                  idx_d      = wcnt_q;
                  trace_d    = vif.best_state;
                  wcnt_d     = '0;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = S_TRACE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end

         S_TRACE: begin
            dbuf_d[idx_q] = trace_q[1];
            trace_d       = {trace_q[0], mem_q[idx_q][trace_q]};
            if (idx_q == '0) begin
               // dbuf[0] is only being written now, so the first bit comes straight from the trace state.
               bit_out_d   = trace_q[1];
               bit_valid_d = 1'b1;
               bit_last_d  = (last_q == '0);
               state_d     = S_OUTPUT;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end

         S_OUTPUT: begin
            if (vif.out_ready) begin
               if (bit_last_q) begin
                  idx_d       = '0;
                  bit_out_d   = 1'b0;
                  bit_valid_d = 1'b0;
                  bit_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = S_WRITE;
               end else begin
                  idx_d      = idx_inc;
                  bit_out_d  = dbuf_q[idx_inc];
                  bit_last_d = (idx_inc == last_q);
               end
            end
         end

         default: begin
            state_d = S_WRITE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q  <= mem_d;
      dbuf_q <= dbuf_d;
      if (rst) begin
         state_q     <= S_WRITE;
         wcnt_q      <= '0;
         last_q      <= '0;
         idx_q       <= '0;
         trace_q     <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         bit_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         trace_q     <= trace_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         bit_last_q  <= bit_last_d;
      end
   end

   assign vif.in_ready  = in_ready_q;
   assign vif.busy      = busy_q;
   assign vif.bit_out   = bit_out_q;
   assign vif.bit_valid = bit_valid_q;
   assign vif.bit_last  = bit_last_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: stimulus pushes hand-derived bits into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_viterbi_traceback;

   logic clk = 1'b0;
   logic rst = 1'b1;

   viterbi_traceback_if vif ();

   viterbi_traceback #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   exp_t       exp_q [$];
   exp_t       mon_e;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         popped = 0;
   int         hs_last_cyc = -1;
   logic       prev_stall = 1'b0;
   logic       prev_bit;
   logic       prev_last;
   int         or_mode = 0;
   logic       or_level = 1'b1;
   logic [3:0] blk_surv [16];

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name, input int waited);
      n_vec++;
      n_err++;
      $display("FAIL %s: no response after %0d cycles (cycle %0d)", name, waited, cyc);
   endtask

   // Scoreboard monitor; also checks outputs hold while stalled.
   always @(negedge clk) begin
      if (rst || !vif.bit_valid) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_bit_hold", vif.bit_out, prev_bit);
            check("stall_last_hold", vif.bit_last, prev_last);
         end
         if (vif.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_bit_queue_size", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("bit_out", vif.bit_out, mon_e.b);
               check("bit_last", vif.bit_last, mon_e.l);
               popped++;
               if (mon_e.l) hs_last_cyc = cyc;
            end
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_bit   = vif.bit_out;
            prev_last  = vif.bit_last;
         end
      end
   end

   // Sole driver of out_ready: level hold or per-cycle toggle.
   initial begin
      vif.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (or_mode == 1) vif.out_ready = ~vif.out_ready;
         else              vif.out_ready = or_level;
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Drives one block from blk_surv; bits[i] is the i-th decoded bit in time order.
   task automatic run_block(input int n, input logic [1:0] best, input bit use_last,
                            input logic [15:0] bits, output int first_acc, output int last_acc);
      exp_t tmp;
      int   budget;
      for (int i = 0; i < n; i++) begin
         tmp.b = bits[i];
         tmp.l = (i == n - 1);
         exp_q.push_back(tmp);
      end
      first_acc = -1;
      last_acc  = -1;
      for (int k = 0; k < n; k++) begin
         vif.surv_valid = 1'b1;
         vif.surv       = blk_surv[k];
         vif.blk_last   = use_last && (k == n - 1);
         vif.best_state = (k == n - 1) ? best : ~best;
         budget = 0;
         forever begin
            @(negedge clk);
            if (vif.in_ready) break;
            budget++;
            if (budget > 200) begin
               timeout_fail("in_ready_wait", budget);
               break;
            end
         end
         if (k == 0) first_acc = cyc;
         last_acc = cyc;
         sync();
      end
      vif.surv_valid = 1'b0;
      vif.blk_last   = 1'b0;
   endtask

   // With out_ready held high: count busy cycles and first-bit latency.
   task automatic observe(input int n, input int acc);
      int low   = 0;
      int first = -1;
      forever begin
         @(negedge clk);
         if (vif.in_ready) break;
         low++;
         if (vif.bit_valid && first < 0) first = cyc;
         if (low > 400) begin
            timeout_fail("observe_in_ready", low);
            break;
         end
      end
      check("in_ready_low_cycles", low, 2 * n);
      check("first_bit_latency", first - acc, n + 1);
   endtask

   task automatic wait_ready();
      int budget = 0;
      forever begin
         @(negedge clk);
         if (vif.in_ready) break;
         budget++;
         if (budget > 400) begin
            timeout_fail("wait_ready", budget);
            break;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, vif.in_ready, 1);
      check({tag, "_bit_valid"}, vif.bit_valid, 0);
      check({tag, "_busy"}, vif.busy, 0);
      check({tag, "_bit_out"}, vif.bit_out, 0);
      check({tag, "_bit_last"}, vif.bit_last, 0);
   endtask

   task automatic load_1011();
      blk_surv[0] = 4'b0000;
      blk_surv[1] = 4'b0000;
      blk_surv[2] = 4'b0100;
      blk_surv[3] = 4'b0000;
   endtask

   task automatic load_0110();
      blk_surv[0] = 4'b1111;
      blk_surv[1] = 4'b1011;
      blk_surv[2] = 4'b0111;
      blk_surv[3] = 4'b0010;
   endtask

   initial begin
      int fa, la, fb, lb, p0, budget;
      vif.surv_valid = 1'b0;
      vif.surv       = 4'b0000;
      vif.blk_last   = 1'b0;
      vif.best_state = 2'd0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      sync();

      // Message 1,0,1,1 with best_state 3.
      load_1011();
      run_block(4, 2'd3, 1'b1, 16'h000D, fa, la);
      observe(4, la);
      sync();

      // Sixteen all-zero steps, no blk_last: forced end.
      for (int i = 0; i < 16; i++) blk_surv[i] = 4'b0000;
      run_block(16, 2'd0, 1'b0, 16'h0000, fa, la);
      observe(16, la);
      sync();

      // Backpressure plus junk inputs while the block is busy.
      or_mode = 1;
      load_1011();
      run_block(4, 2'd3, 1'b1, 16'h000D, fa, la);
      vif.surv_valid = 1'b1;
      vif.surv       = 4'b1111;
      vif.blk_last   = 1'b1;
      vif.best_state = 2'd0;
      repeat (3) @(posedge clk);
      #1 vif.surv_valid = 1'b0;
      vif.blk_last = 1'b0;
      wait_ready();
      sync();
      or_mode  = 0;
      or_level = 1'b1;
      sync();

      // Length-1 block, best_state 2.
      blk_surv[0] = 4'b0000;
      run_block(1, 2'd2, 1'b1, 16'h0001, fa, la);
      observe(1, la);
      check("len1_after_valid", vif.bit_valid, 0);
      check("len1_after_busy", vif.busy, 0);
      @(negedge clk);
      check("len1_in_ready_2cyc", vif.in_ready, 1);
      sync();

      // Back-to-back: second block waits on in_ready and lands right after the last handshake.
      blk_surv[0] = 4'b0000;
      run_block(1, 2'd2, 1'b1, 16'h0001, fa, la);
      load_0110();
      run_block(4, 2'd1, 1'b1, 16'h0006, fb, lb);
      check("back_to_back_accept", fb - hs_last_cyc, 1);
      observe(4, lb);
      sync();

      // Reset during OUTPUT after two bits.
      or_level = 1'b0;
      load_1011();
      run_block(4, 2'd3, 1'b1, 16'h000D, fa, la);
      budget = 0;
      forever begin
         @(negedge clk);
         if (vif.bit_valid) break;
         budget++;
         if (budget > 100) begin
            timeout_fail("wait_bit_valid", budget);
            break;
         end
      end
      p0 = popped;
      sync();
      or_level = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      or_level = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_bits_taken", popped - p0, 2);
      check("mid_rst_bit_valid", vif.bit_valid, 0);
      check("mid_rst_busy", vif.busy, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("mid_rst_release");
      sync();
      or_level = 1'b1;

      load_0110();
      run_block(4, 2'd1, 1'b1, 16'h0006, fa, la);
      observe(4, la);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
